// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared state, opcode, funct, ALU and mux-select constants for the multi-cycle MIPS control
package mips_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps FSM alu_op plus funct to the 4-bit ALU control code
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       funct_illegal
);

    always_comb begin
        alu_ctrl      = ALU_ADD;
        funct_illegal = 1'b0;
        case (alu_op)
            ALU_OP_SUB: alu_ctrl = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct)
                    F_ADD:   alu_ctrl = ALU_ADD;
                    F_SUB:   alu_ctrl = ALU_SUB;
                    F_AND:   alu_ctrl = ALU_AND;
                    F_OR:    alu_ctrl = ALU_OR;
                    F_SLT:   alu_ctrl = ALU_SLT;
                    default: funct_illegal = 1'b1;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - Moore control FSM sequencing the shared multi-cycle MIPS datapath
module mips_mc_control
    import mips_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    output logic                  pc_en,
    output logic                  iord,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic [1:0]            pc_src,
    output logic                  illegal,
    output logic [3:0]            state_dbg
);

    state_e     state_q, state_d;
    logic       pc_write, branch, alu_on;
    logic [1:0] alu_op;
    logic [3:0] dec_ctrl;
    logic       funct_illegal;

    alu_decoder u_alu_decoder (
        .alu_op        (alu_op),
        .funct         (funct),
        .alu_ctrl      (dec_ctrl),
        .funct_illegal (funct_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = S_FETCH;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        pc_src     = PC_ALU;
        alu_op     = ALU_OP_ADD;
        alu_on     = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_on    = 1'b1;
                pc_write  = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                alu_src_b = SRCB_IMM_SH;
                alu_on    = 1'b1;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_on    = 1'b1;
                state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                state_d  = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_FUNCT;
                alu_on    = 1'b1;
                illegal   = funct_illegal;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_SUB;
                alu_on    = 1'b1;
                branch    = 1'b1;
                pc_src    = PC_ALUOUT;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_on    = 1'b1;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src   = PC_JUMP;
                pc_write = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign pc_en     = pc_write | (branch & zero);
    assign alu_ctrl  = alu_on ? dec_ctrl : '0;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// tb/tb_mips_mc_control.sv - table-driven bench for mips_mc_control
module tb_mips_mc_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [3:0] alu_ctrl, state_dbg;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_mc_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_ctrl(alu_ctrl), .pc_src(pc_src), .illegal(illegal), .state_dbg(state_dbg)
    );

    // Packed as {pc_en,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a, src_b, alu_ctrl, pc_src, illegal}
    logic [17:0] got;
    assign got = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal};

    localparam logic [17:0] E_IDLE    = 18'd0;
    localparam logic [17:0] E_FETCH   = {9'b1_0_1_0_1_0_0_0_0, 2'b01, 4'b0010, 2'b00, 1'b0};
    localparam logic [17:0] E_DEC     = {9'b0_0_0_0_0_0_0_0_0, 2'b11, 4'b0010, 2'b00, 1'b0};
    localparam logic [17:0] E_DEC_ILL = {9'b0_0_0_0_0_0_0_0_0, 2'b11, 4'b0010, 2'b00, 1'b1};
    localparam logic [17:0] E_MEMADR  = {9'b0_0_0_0_0_0_0_0_1, 2'b10, 4'b0010, 2'b00, 1'b0};
    localparam logic [17:0] E_MEMRD   = {9'b0_1_1_0_0_0_0_0_0, 2'b00, 4'b0000, 2'b00, 1'b0};
    localparam logic [17:0] E_MEMWB   = {9'b0_0_0_0_0_0_1_1_0, 2'b00, 4'b0000, 2'b00, 1'b0};
    localparam logic [17:0] E_MEMWR   = {9'b0_1_0_1_0_0_0_0_0, 2'b00, 4'b0000, 2'b00, 1'b0};
    localparam logic [17:0] E_EX_ADD  = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 4'b0010, 2'b00, 1'b0};
    localparam logic [17:0] E_EX_SUB  = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 4'b0110, 2'b00, 1'b0};
    localparam logic [17:0] E_EX_AND  = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 4'b0000, 2'b00, 1'b0};
    localparam logic [17:0] E_EX_OR   = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 4'b0001, 2'b00, 1'b0};
    localparam logic [17:0] E_EX_SLT  = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 4'b0111, 2'b00, 1'b0};
    localparam logic [17:0] E_EX_ILL  = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 4'b0010, 2'b00, 1'b1};
    localparam logic [17:0] E_ALUWB   = {9'b0_0_0_0_0_1_0_1_0, 2'b00, 4'b0000, 2'b00, 1'b0};
    localparam logic [17:0] E_BR_T    = {9'b1_0_0_0_0_0_0_0_1, 2'b00, 4'b0110, 2'b01, 1'b0};
    localparam logic [17:0] E_BR_N    = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 4'b0110, 2'b01, 1'b0};
    localparam logic [17:0] E_ADDIWB  = {9'b0_0_0_0_0_0_0_1_0, 2'b00, 4'b0000, 2'b00, 1'b0};
    localparam logic [17:0] E_JUMP    = {9'b1_0_0_0_0_0_0_0_0, 2'b00, 4'b0000, 2'b10, 1'b0};

    localparam logic [3:0] T_IDLE = 0, T_FETCH = 1, T_DEC = 2, T_MEMADR = 3, T_MEMRD = 4,
                           T_MEMWB = 5, T_MEMWR = 6, T_EXEC = 7, T_ALUWB = 8, T_BRANCH = 9,
                           T_ADDIEX = 10, T_ADDIWB = 11, T_JUMP = 12;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                           BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic [3:0]  st;
        logic [17:0] out;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic [3:0] st, input logic [17:0] out);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.z = z; v.st = st; v.out = out;
        tbl.push_back(v);
    endtask

    task automatic check_now(input int idx, input logic [3:0] st, input logic [17:0] out);
        checks++;
        if (state_dbg !== st) begin
            errors++;
            $display("FAIL row %0d state: got %0d want %0d", idx, state_dbg, st);
        end
        checks++;
        if (got !== out) begin
            errors++;
            $display("FAIL row %0d outputs: got %b want %b", idx, got, out);
        end
    endtask

    task automatic apply_row(input int idx, input vec_t v);
        @(negedge clk);
        rst_n = v.rst; opcode = v.op; funct = v.fn; zero = v.z;
        #1;
        check_now(idx, v.st, v.out);
    endtask

    initial begin
        add(0, RT, 6'd0, 0, T_IDLE, E_IDLE);
        add(0, RT, 6'd0, 0, T_IDLE, E_IDLE);
        add(1, RT, 6'd0, 0, T_IDLE, E_IDLE);
        // lw: 5 cycles
        add(1, LW, 6'd0, 0, T_FETCH, E_FETCH);
        add(1, LW, 6'd0, 0, T_DEC, E_DEC);
        add(1, LW, 6'd0, 0, T_MEMADR, E_MEMADR);
        add(1, LW, 6'd0, 0, T_MEMRD, E_MEMRD);
        add(1, LW, 6'd0, 0, T_MEMWB, E_MEMWB);
        // R-type variants: 4 cycles each
        add(1, RT, 6'b101010, 0, T_FETCH, E_FETCH);
        add(1, RT, 6'b101010, 0, T_DEC, E_DEC);
        add(1, RT, 6'b101010, 0, T_EXEC, E_EX_SLT);
        add(1, RT, 6'b101010, 0, T_ALUWB, E_ALUWB);
        add(1, RT, 6'b100010, 0, T_FETCH, E_FETCH);
        add(1, RT, 6'b100010, 0, T_DEC, E_DEC);
        add(1, RT, 6'b100010, 0, T_EXEC, E_EX_SUB);
        add(1, RT, 6'b100010, 0, T_ALUWB, E_ALUWB);
        add(1, RT, 6'b100100, 0, T_FETCH, E_FETCH);
        add(1, RT, 6'b100100, 0, T_DEC, E_DEC);
        add(1, RT, 6'b100100, 0, T_EXEC, E_EX_AND);
        add(1, RT, 6'b100100, 0, T_ALUWB, E_ALUWB);
        add(1, RT, 6'b100101, 0, T_FETCH, E_FETCH);
        add(1, RT, 6'b100101, 0, T_DEC, E_DEC);
        add(1, RT, 6'b100101, 0, T_EXEC, E_EX_OR);
        add(1, RT, 6'b100101, 0, T_ALUWB, E_ALUWB);
        add(1, RT, 6'b100000, 0, T_FETCH, E_FETCH);
        add(1, RT, 6'b100000, 0, T_DEC, E_DEC);
        add(1, RT, 6'b100000, 0, T_EXEC, E_EX_ADD);
        add(1, RT, 6'b100000, 0, T_ALUWB, E_ALUWB);
        add(1, RT, 6'b111111, 0, T_FETCH, E_FETCH);
        add(1, RT, 6'b111111, 0, T_DEC, E_DEC);
        add(1, RT, 6'b111111, 0, T_EXEC, E_EX_ILL);
        add(1, RT, 6'b111111, 0, T_ALUWB, E_ALUWB);
        // beq taken then not taken: 3 cycles each
        add(1, BEQ, 6'd0, 1, T_FETCH, E_FETCH);
        add(1, BEQ, 6'd0, 1, T_DEC, E_DEC);
        add(1, BEQ, 6'd0, 1, T_BRANCH, E_BR_T);
        add(1, BEQ, 6'd0, 0, T_FETCH, E_FETCH);
        add(1, BEQ, 6'd0, 0, T_DEC, E_DEC);
        add(1, BEQ, 6'd0, 0, T_BRANCH, E_BR_N);
        // addi: 4 cycles
        add(1, ADDI, 6'd0, 0, T_FETCH, E_FETCH);
        add(1, ADDI, 6'd0, 0, T_DEC, E_DEC);
        add(1, ADDI, 6'd0, 0, T_ADDIEX, E_MEMADR);
        add(1, ADDI, 6'd0, 0, T_ADDIWB, E_ADDIWB);
        // sw: 4 cycles, j: 3 cycles, illegal opcode: 2 cycles
        add(1, SW, 6'd0, 0, T_FETCH, E_FETCH);
        add(1, SW, 6'd0, 0, T_DEC, E_DEC);
        add(1, SW, 6'd0, 0, T_MEMADR, E_MEMADR);
        add(1, SW, 6'd0, 0, T_MEMWR, E_MEMWR);
        add(1, JMP, 6'd0, 0, T_FETCH, E_FETCH);
        add(1, JMP, 6'd0, 0, T_DEC, E_DEC);
        add(1, JMP, 6'd0, 0, T_JUMP, E_JUMP);
        add(1, BAD, 6'd0, 0, T_FETCH, E_FETCH);
        add(1, BAD, 6'd0, 0, T_DEC, E_DEC_ILL);
        add(1, LW, 6'd0, 0, T_FETCH, E_FETCH);
        add(1, LW, 6'd0, 0, T_DEC, E_DEC);

        for (int i = 0; i < tbl.size(); i++) apply_row(i, tbl[i]);

        // Asynchronous reset in the middle of MEMWR
        begin
            vec_t r;
            r.rst = 0; r.op = SW; r.fn = 0; r.z = 0; r.st = T_IDLE; r.out = E_IDLE;
            apply_row(100, r);
            r.rst = 1;
            apply_row(101, r);
            r.st = T_FETCH; r.out = E_FETCH;  apply_row(102, r);
            r.st = T_DEC;   r.out = E_DEC;    apply_row(103, r);
            r.st = T_MEMADR; r.out = E_MEMADR; apply_row(104, r);
            r.st = T_MEMWR; r.out = E_MEMWR;  apply_row(105, r);
            #2;
            rst_n = 1'b0;
            #1;
            check_now(106, T_IDLE, E_IDLE);
            r.rst = 1; r.st = T_IDLE; r.out = E_IDLE; apply_row(107, r);
            r.st = T_FETCH; r.out = E_FETCH;          apply_row(108, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Main control unit for the multi-cycle MIPS core.
- A Moore FSM sequences the shared datapath (memory, IR, register file, single ALU, PC) through fetch, decode, execute, memory and writeback steps.
- Drives the 4-bit ALU control code directly, using a local funct decoder.
- Sits between the instruction register (opcode/funct) and every datapath enable and mux select.

Parameters:
ALU_CTRL_W, 4, width of alu_ctrl; fixed by the ALU encoding.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag, combinational from the current ALU result
pc_en  output  1  PC register load enable
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  instruction register load
reg_dst  output  1  write register select: 0 = rt, 1 = rd
mem_to_reg  output  1  write data select: 0 = ALUOut, 1 = MDR
reg_write  output  1  register file write enable
alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A
alu_src_b  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
alu_ctrl  output  4  ALU operation code
pc_src  output  2  PC next select: 00 = ALU result, 01 = ALUOut, 10 = jump target
illegal  output  1  one-cycle pulse in DECODE on an unsupported opcode, or in EXECUTE on an unsupported funct
state_dbg  output  4  current state encoding, for the bench

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n).
- rst_n low: state = IDLE. In IDLE every output is 0, including alu_ctrl = 0000 and state_dbg = 0.
- IDLE -> FETCH unconditionally on the first edge after reset release.
- Outputs are Moore, decoded from state. Two exceptions are combinational:
  - pc_en = pc_write | (branch & zero).
  - alu_ctrl in EXECUTE is derived from funct.
- Any output not listed for a state is 0.
- Per-state outputs and transitions:
  - FETCH: mem_read, ir_write, src_b = 01, alu_ctrl = 0010, pc_src = 00, pc_write. Next: DECODE.
  - DECODE: src_b = 11, alu_ctrl = 0010 (branch target into ALUOut). Next by opcode:
    - 100011 (lw) / 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXECUTE
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - any other opcode -> FETCH, with illegal = 1
  - MEMADR: src_a = 1, src_b = 10, alu_ctrl = 0010. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD: iord, mem_read. Next: MEMWB.
  - MEMWB: mem_to_reg, reg_write (reg_dst = 0). Next: FETCH.
  - MEMWR: iord, mem_write. Next: FETCH.
  - EXECUTE: src_a = 1, src_b = 00, alu_ctrl by funct:
    - 100000 (add) -> 0010
    - 100010 (sub) -> 0110
    - 100100 (and) -> 0000
    - 100101 (or) -> 0001
    - 101010 (slt) -> 0111
    - any other funct -> 0010, with illegal = 1
    - Next: ALUWB.
  - ALUWB: reg_dst = 1, reg_write. Next: FETCH.
  - BRANCH: src_a = 1, src_b = 00, alu_ctrl = 0110, branch, pc_src = 01. Next: FETCH.
  - ADDIEX: src_a = 1, src_b = 10, alu_ctrl = 0010. Next: ADDIWB.
  - ADDIWB: reg_write (reg_dst = 0, mem_to_reg = 0). Next: FETCH.
  - JUMP: pc_src = 10, pc_write. Next: FETCH.
- Instruction cycle counts, FETCH to FETCH inclusive of FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
- mem_read and mem_write are never both 1. reg_write and mem_write are never both 1.
- opcode and funct are sampled only in DECODE, MEMADR and EXECUTE. IR stability is guaranteed because ir_write is high only in FETCH.
- Reset asserted mid-instruction: return to IDLE immediately (asynchronous). All strobes drop in the same cycle, and no partial writeback occurs.
- Unused state encodings are treated as FETCH on the next edge; outputs in them are 0.

Decomposition:
- Shared package mips_pkg holds:
  - state localparams S_IDLE .. S_JUMP
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - ALU codes ALU_ADD = 0010, ALU_SUB = 0110, ALU_AND = 0000, ALU_OR = 0001, ALU_SLT = 0111
  - src_b and pc_src select constants
- One sub-module, alu_decoder: combinational; inputs alu_op[1:0] and funct; outputs alu_ctrl and funct_illegal. The FSM supplies alu_op: 00 = add, 01 = sub, 10 = use funct.

Test Plan:
- Reset then release -> IDLE for 1 cycle, then FETCH; in FETCH mem_read = ir_write = pc_en = 1, alu_src_b = 01, alu_ctrl = 0010.
- lw (opcode 100011) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; iord = 1 in MEMRD; reg_write = 1 with mem_to_reg = 1 only in MEMWB.
- R-type with funct 101010 / 100010 / 100100 -> alu_ctrl 0111 / 0110 / 0000 in EXECUTE; ALUWB has reg_dst = 1, reg_write = 1; funct 111111 -> illegal pulse, alu_ctrl 0010.
- beq with zero = 1 -> pc_en = 1, pc_src = 01 in BRANCH; repeat with zero = 0 -> pc_en = 0; both return to FETCH after 3 cycles.
- sw, then j, then opcode 111111 -> mem_write only in MEMWR with iord = 1; JUMP drives pc_src = 10, pc_en = 1; illegal pulses in DECODE, followed by FETCH.
- rst_n dropped during MEMWR -> mem_write falls in the same cycle, state_dbg = 0; after release the sequence restarts IDLE, FETCH.
